// File: rtl/rv32_pkg.sv
// Shared RV32 fetch types and constants: NOP encoding, fetch FSM states and
// the {pc, instr} entry held in the instruction buffer.
package rv32_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        IFS_IDLE,
        IFS_REQ
    } ifs_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous instruction buffer with flush; head is read combinationally.
// Push while full is accepted only when a pop frees the slot in the same cycle.
module instr_fifo
    import rv32_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, single-outstanding memory request FSM, redirect/discard handling
// and instruction buffer. Define IFETCH_PERF_EN to add fetch_count/stall_count.
module instruction_fetch
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    ifs_state_e       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      addr_q, addr_d;
    logic             discard_q, discard_d;

    fetch_entry_t     fifo_head;
    fetch_entry_t     push_data;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] count_next;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    assign pop       = instr_valid && instr_ready;
    assign push      = (state_q == IFS_REQ) && mem_ack && !discard_q && !redirect
                       && (!fifo_full || pop);
    assign push_data = '{pc: addr_q, instr: mem_rdata};

    instr_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Occupancy after this edge; decides whether another request may be issued.
    always_comb begin
        count_next = '0;
        if (!redirect) begin
            count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        discard_d = discard_q;
        if (redirect) begin
            pc_d = redirect_pc & ~32'h3;
        end
        case (state_q)
            IFS_IDLE: begin
                if (count_next < DEPTH_CNT) begin
                    state_d = IFS_REQ;
                end
            end
            IFS_REQ: begin
                if (mem_ack) begin
                    if (!discard_q && !redirect) begin
                        pc_d = addr_q + 32'd4;
                    end
                    discard_d = 1'b0;
                    if (count_next >= DEPTH_CNT) begin
                        state_d = IFS_IDLE;
                    end
                end else if (redirect) begin
                    discard_d = 1'b1;
                end
            end
            default: state_d = IFS_IDLE;
        endcase
        // An unacked request keeps its address even across a redirect.
        if (!(state_q == IFS_REQ && !mem_ack)) begin
            addr_d = pc_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IFS_IDLE;
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            discard_q <= discard_d;
        end
    end

    assign mem_req     = (state_q == IFS_REQ);
    assign mem_addr    = addr_q;
    assign instr_valid = !fifo_empty;
    assign instruction = instr_valid ? fifo_head.instr : NOP_INSTR;
    assign instr_pc    = instr_valid ? fifo_head.pc : RESET_PC;

`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q + 32'(pop);
        stall_count_d = stall_count_q + 32'(instr_ready && !instr_valid);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected {pc, word} pairs are queued as
// stimulus is set up and checked as decode accepts them.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_q [$];
    bit          auto_mem = 1'b0;
    bit          stray_ack = 1'b0;
    int          gap = 1;
    int          wait_cnt = 0;

    instruction_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instruction (instruction),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef IFETCH_PERF_EN
        ,
        .fetch_count (fetch_count),
        .stall_count (stall_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC3A5_0F1E;
    endfunction

    // Memory model: acks the pending request after 'gap' cycles, or a stray ack on demand.
    always @(posedge clk) begin
        #1;
        if (stray_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hDEAD_BEEF;
        end else if (reset || mem_ack) begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end else if (mem_req && auto_mem) begin
            wait_cnt++;
            if (wait_cnt >= gap) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_word(mem_addr);
            end
        end else begin
            wait_cnt = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic sb_monitor();
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!reset && instr_valid && instr_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_extra: got pc=%h instr=%h, required no delivery", instr_pc, instruction);
                end else begin
                    e = exp_q.pop_front();
                    if (instr_pc !== e || instruction !== mem_word(e)) begin
                        n_fail++;
                        $display("FAIL sb_order: got pc=%h instr=%h, required pc=%h instr=%h",
                                 instr_pc, instruction, e, mem_word(e));
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        redirect  = 1'b0;
        stray_ack = 1'b0;
        step();
        step();
        exp_q.delete();
        reset = 1'b0;
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            step();
            t++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_drain: %0d words still expected, required 0", nm, exp_q.size());
        end
    endtask

    task automatic test_reset();
        instr_ready = 1'b0;
        auto_mem    = 1'b0;
        reset       = 1'b1;
        step();
        step();
        n_cmp++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mem: got req=%b addr=%h, required req=0 addr=00000000", mem_req, mem_addr);
        end
        n_cmp++;
        if (instr_valid !== 1'b0 || instruction !== 32'h0000_0013 || instr_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out: got valid=%b instr=%h pc=%h, required 0/00000013/00000000",
                     instr_valid, instruction, instr_pc);
        end
        reset = 1'b0;
        step();
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_first_req: got req=%b addr=%h, required req=1 addr=00000000", mem_req, mem_addr);
        end
    endtask

    task automatic test_fetch_order();
        int t = 0;
        gap         = 2;
        auto_mem    = 1'b1;
        instr_ready = 1'b1;
        do_reset();
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        while (!mem_ack && t < 50) begin
            step();
            t++;
        end
        n_cmp++;
        if (instr_valid !== 1'b0 || mem_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL order_ack_cycle: got ack=%b valid=%b, required ack=1 valid=0", mem_ack, instr_valid);
        end
        step();
        n_cmp++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL order_latency: got valid=%b pc=%h, required valid=1 pc=00000000", instr_valid, instr_pc);
        end
        drain("order");
        instr_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        gap         = 1;
        auto_mem    = 1'b1;
        instr_ready = 1'b0;
        do_reset();
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        repeat (10) step();
        n_cmp++;
        if (instr_valid !== 1'b1 || mem_req !== 1'b0 || instr_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL bp_full: got valid=%b req=%b pc=%h, required valid=1 req=0 pc=00000000",
                     instr_valid, mem_req, instr_pc);
        end
        n_cmp++;
        if (mem_addr !== 32'h8) begin
            n_fail++;
            $display("FAIL bp_next_pc: got addr=%h, required 00000008", mem_addr);
        end
        instr_ready = 1'b1;
        drain("bp");
        instr_ready = 1'b0;
    endtask

    task automatic test_redirect_inflight();
        int t = 0;
        gap         = 3;
        auto_mem    = 1'b1;
        instr_ready = 1'b1;
        do_reset();
        exp_q = '{32'h0, 32'h4};
        while (!(mem_req && mem_addr == 32'h8 && !mem_ack) && t < 50) begin
            step();
            t++;
        end
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL redir_pre: got %0d undelivered, required 0", exp_q.size());
        end
        exp_q.delete();
        exp_q = '{32'h100, 32'h104};
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin
            n_fail++;
            $display("FAIL redir_hold: got req=%b addr=%h, required req=1 addr=00000008", mem_req, mem_addr);
        end
        t = 0;
        while (!mem_ack && t < 50) begin
            step();
            t++;
        end
        step();
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_restart: got req=%b addr=%h valid=%b, required req=1 addr=00000100 valid=0",
                     mem_req, mem_addr, instr_valid);
        end
        drain("redir");
        instr_ready = 1'b0;
    endtask

    task automatic test_redirect_on_ack();
        int t = 0;
        gap         = 2;
        auto_mem    = 1'b1;
        instr_ready = 1'b0;
        do_reset();
        while (!mem_ack && t < 50) begin
            step();
            t++;
        end
        redirect    = 1'b1;
        redirect_pc = 32'h203;
        step();
        redirect = 1'b0;
        n_cmp++;
        if (instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ackredir_drop: got valid=%b pc=%h, required valid=0", instr_valid, instr_pc);
        end
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL ackredir_addr: got req=%b addr=%h, required req=1 addr=00000200", mem_req, mem_addr);
        end
        exp_q = '{32'h200, 32'h204};
        instr_ready = 1'b1;
        drain("ackredir");
        instr_ready = 1'b0;
    endtask

    task automatic test_reset_midreq();
        int t = 0;
        gap         = 4;
        auto_mem    = 1'b1;
        instr_ready = 1'b1;
        do_reset();
        exp_q = '{32'h0};
        while (!(mem_req && mem_addr == 32'h4) && t < 50) begin
            step();
            t++;
        end
        step();
        reset = 1'b1;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h0 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_clear: got req=%b addr=%h valid=%b, required 0/00000000/0",
                     mem_req, mem_addr, instr_valid);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_pre: got %0d undelivered, required 0", exp_q.size());
        end
        exp_q.delete();
        stray_ack = 1'b1;
        step();
        reset     = 1'b0;
        stray_ack = 1'b0;
        step();
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_restart: got req=%b addr=%h valid=%b, required req=1 addr=00000000 valid=0",
                     mem_req, mem_addr, instr_valid);
        end
        exp_q = '{32'h0, 32'h4};
        drain("midreset");
        instr_ready = 1'b0;
    endtask

`ifdef IFETCH_PERF_EN
    task automatic test_perf();
        int delivered = 0;
        gap         = 1;
        auto_mem    = 1'b0;
        instr_ready = 1'b0;
        do_reset();
        n_cmp++;
        if (fetch_count !== 32'd0 || stall_count !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_reset: got fetch=%0d stall=%0d, required 0/0", fetch_count, stall_count);
        end
        instr_ready = 1'b1;
        repeat (3) step();
        instr_ready = 1'b0;
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        auto_mem = 1'b1;
        for (int t = 0; t < 100 && delivered < 5; t++) begin
            if (instr_valid) begin
                instr_ready = 1'b1;
                delivered++;
            end else begin
                instr_ready = 1'b0;
            end
            step();
        end
        instr_ready = 1'b0;
        n_cmp++;
        if (fetch_count !== 32'd5 || stall_count !== 32'd3) begin
            n_fail++;
            $display("FAIL perf_counts: got fetch=%0d stall=%0d, required 5/3", fetch_count, stall_count);
        end
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        step();
        n_cmp++;
        if (fetch_count !== 32'd5 || stall_count !== 32'd3) begin
            n_fail++;
            $display("FAIL perf_redirect: got fetch=%0d stall=%0d, required 5/3", fetch_count, stall_count);
        end
    endtask
`endif

    initial begin
        fork
            sb_monitor();
        join_none
        test_reset();
        test_fetch_order();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_on_ack();
        test_reset_midreq();
`ifdef IFETCH_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
